// File: rtl/time_keeper.sv
// 12-hour BCD time-of-day counter with a clock prescaler for the one-second base.
// Time-set mode loads a sanitized external value; run mode advances once per CLK_DIV cycles.
module time_keeper #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  STATE,
  input  logic [18:0] timeset,
  output logic [18:0] time_out,
  output logic        sec_tick
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(CLK_DIV - 1);

  logic [18:0]   time_d, time_q;
  logic [PW-1:0] presc_d, presc_q;
  logic          tick_d, tick_q;

  // Illegal fields load as zero; an hour past 11 loads as 00.
  function automatic logic [18:0] sanitize(input logic [18:0] t);
    logic [3:0] s1, m1;
    logic [2:0] s10, m10;
    logic [4:0] hr;
    s1  = (t[3:0]   > 4'd9) ? 4'd0 : t[3:0];
    s10 = (t[6:4]   > 3'd5) ? 3'd0 : t[6:4];
    m1  = (t[10:7]  > 4'd9) ? 4'd0 : t[10:7];
    m10 = (t[13:11] > 3'd5) ? 3'd0 : t[13:11];
    if ((t[18] && (t[17:14] > 4'd1)) || (!t[18] && (t[17:14] > 4'd9))) begin
      hr = 5'd0;
    end else begin
      hr = t[18:14];
    end
    return {hr, m10, m1, s10, s1};
  endfunction

  function automatic logic [18:0] incr(input logic [18:0] t);
    logic [3:0] s1, m1, h1;
    logic [2:0] s10, m10;
    logic       h10;
    {h10, h1, m10, m1, s10, s1} = t;
    if (s1 != 4'd9) begin
      s1 = s1 + 4'd1;
    end else begin
      s1 = 4'd0;
      if (s10 != 3'd5) begin
        s10 = s10 + 3'd1;
      end else begin
        s10 = 3'd0;
        if (m1 != 4'd9) begin
          m1 = m1 + 4'd1;
        end else begin
          m1 = 4'd0;
          if (m10 != 3'd5) begin
            m10 = m10 + 3'd1;
          end else begin
            m10 = 3'd0;
            if (!h10 && (h1 == 4'd9)) begin
              h10 = 1'b1;
              h1  = 4'd0;
            end else if (h10 && (h1 == 4'd1)) begin
              h10 = 1'b0;
              h1  = 4'd0;
            end else begin
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (STATE == 2'b01) begin
      time_d  = sanitize(timeset);
      presc_d = '0;
    end else if (presc_q == PrescMax) begin
      presc_d = '0;
      time_d  = incr(time_q);
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      time_q  <= time_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign time_out = time_q;
  assign sec_tick = tick_q;

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter CLK_DIV, default 50000000, meaning clk cycles per one-second increment (legal range 2 to 2^26).
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port STATE  input  2  mode; 2'b01 = time-set mode, any other value = run mode.
REQ-005 Port timeset  input  19  packed BCD time from the time-set block: [3:0] sec ones, [6:4] sec tens, [10:7] min ones, [13:11] min tens, [17:14] hour ones, [18] hour tens.
REQ-006 Port time_out  output  19  current time, same packing as timeset, registered.
REQ-007 Port sec_tick  output  1  one-cycle pulse on each cycle in which time_out advances by one second.

Function
REQ-008 Timekeeping SHALL use a 12-hour range, 00:00:00 to 11:59:59; every field SHALL stay BCD-legal (sec/min ones 0-9, sec/min tens 0-5, hour 00-11).
REQ-009 Set mode: while STATE==2'b01, time_out SHALL load the sanitized timeset on every clock; the prescaler SHALL be held at 0; sec_tick SHALL stay 0.
REQ-010 Sanitize: any field over its legal maximum SHALL load as 0 (per field independently); an hour of 1x with x>1 SHALL load as 00.
REQ-011 Set-to-run: the value loaded on the last set-mode cycle SHALL be kept; the first increment SHALL occur exactly CLK_DIV cycles after the first run-mode cycle.
REQ-012 Run mode: the prescaler SHALL count 0..CLK_DIV-1; on the cycle it equals CLK_DIV-1 it SHALL wrap to 0, time_out SHALL advance by one second on that edge, and sec_tick SHALL be 1 for that single cycle.
REQ-013 Carry: sec ones 9->0 carries to sec tens; sec tens 5->0 carries to min ones; min ones 9->0 carries to min tens; min tens 5->0 carries to hour; all carries resolve within the same edge (no intermediate values visible).
REQ-014 Hour: 09->10; 11 with minute/second carry -> 00 (time_out = 0); no other hour transition.
REQ-015 Run-to-set: entering set mode SHALL abort a partial prescale count with no increment and no sec_tick on that cycle.
REQ-016 Changes between run-mode STATE values (00/10/11) SHALL NOT disturb counting or the prescaler.
REQ-017 time_out SHALL change only on reset, in set mode, or on a sec_tick cycle.

Reset
REQ-018 rst==1 SHALL on the next edge force time_out=19'h0, prescaler=0, sec_tick=0, overriding STATE and timeset.
REQ-019 Reset asserted mid-count SHALL discard the partial prescale; after release, the first increment SHALL occur CLK_DIV cycles later (run mode) or loading SHALL resume immediately (set mode).
REQ-020 No output SHALL be X after the first reset edge.

Verification (CLK_DIV=4 unless stated)
REQ-021 Reset, STATE=00 held 12 cycles after release -> sec_tick on cycles 4, 8, 12; time_out = 00:00:01, 00:00:02, 00:00:03.
REQ-022 STATE=01 with timeset=11:59:58, then STATE=00 -> after 4 cycles 11:59:59, after 8 cycles 00:00:00 (19'h0), sec_tick each time.
REQ-023 Load 09:59:59, run -> one tick gives 10:00:00; load 00:09:59 -> 00:10:00; load 00:59:59 -> 01:00:00.
REQ-024 timeset with sec ones=4'hC, min tens=3'd7, hour=1/4'd5 in set mode -> time_out sec ones 0, min tens 0, hour 00, other fields as given.
REQ-025 Run 3 cycles then STATE=01 then STATE=00 -> no tick during abort; next tick exactly 4 cycles after return to run mode.
REQ-026 rst pulsed for 1 cycle at prescaler=2 in run mode -> time_out=0 next cycle, next sec_tick 4 cycles after rst deasserts; STATE toggling 00->10->11 mid-count -> tick period unchanged.
